// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Optional round-robin tie-break when DMEM_ARB_RR_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   tie_pick1;
    logic   contend;

`ifdef DMEM_ARB_RR_EN
    // last_gnt = 1 means requester 1 was served most recently
    logic last_gnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last_gnt <= 1'b1;
        end else if (state == GNT0) begin
            last_gnt <= 1'b0;
        end else if (state == GNT1) begin
            last_gnt <= 1'b1;
        end
    end

    assign tie_pick1 = ~last_gnt;
`else
    assign tie_pick1 = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nx = tie_pick1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_nx = GNT0;
                end else if (req1) begin
                    state_nx = GNT1;
                end else begin
                    state_nx = IDLE;
                end
            end
            GNT0:    state_nx = req1 ? GNT1 : IDLE;
            GNT1:    state_nx = req0 ? GNT0 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        unique case (1'b1)
            gnt0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = we0;
                mem_re    = ~we0;
            end
            gnt1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = we1;
                mem_re    = ~we1;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
                mem_re    = 1'b0;
            end
        endcase
    end

    // a cycle is contended when someone waits while the other side is served
    assign contend = ((state == IDLE) && req0 && req1)
                   || ((state == GNT0) && req1)
                   || ((state == GNT1) && req0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            conflict_cnt <= 16'd0;
        end else if (contend && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    // memory returns data one cycle after mem_re, i.e. in the rvalid cycle
    assign rdata0 = rvalid0 ? mem_rdata : '0;
    assign rdata1 = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expectations,
// a negedge monitor pops and compares grants and read responses.
module tb_dmem_arbiter;

    logic        CLK;
    logic        RSTn;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    int checks   = 0;
    int failures = 0;
    logic sb_on;
    logic first;

    typedef struct {
        logic        id;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [15:0] cnt;
    } gexp_t;

    gexp_t       gq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    gexp_t       e;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_g(input logic id, input logic [9:0] a,
                          input logic [31:0] d, input logic w,
                          input logic [15:0] c);
        gexp_t g;
        g.id = id; g.addr = a; g.wdata = d;
        g.we = w; g.re = ~w; g.cnt = c;
        gq.push_back(g);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RSTn && sb_on) begin
            chk("mutex", {30'd0, gnt0 & gnt1, mem_we & mem_re}, 32'd0);
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {30'd0, gnt1, gnt0}, 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_id", {30'd0, gnt1, gnt0},
                        e.id ? 32'd2 : 32'd1);
                    chk("mem_addr", {22'd0, mem_addr}, {22'd0, e.addr});
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("mem_re", {31'd0, mem_re}, {31'd0, e.re});
                    chk("cnt_at_gnt", {16'd0, conflict_cnt},
                        {16'd0, e.cnt});
                end
            end
        end
        if (rvalid0) begin
            if (rq0.size() == 0) chk("unexpected_rvalid0", 32'd1, 32'd0);
            else chk("rdata0", rdata0, rq0.pop_front());
        end
        if (rvalid1) begin
            if (rq1.size() == 0) chk("unexpected_rvalid1", 32'd1, 32'd0);
            else chk("rdata1", rdata1, rq1.pop_front());
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, "_mem_we_re"}, {30'd0, mem_we, mem_re}, 32'd0);
        chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata0"}, rdata0, 32'd0);
        chk({tag, "_rdata1"}, rdata1, 32'd0);
        chk({tag, "_cnt"}, {16'd0, conflict_cnt}, 32'd0);
    endtask

    initial begin
`ifdef DMEM_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        sb_on = 1'b1;
        RSTn = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        tick;
        RSTn = 1'b1;

        // single read on requester 0
        req0 = 1; we0 = 0; addr0 = 10'h004; wdata0 = '0;
        mem_rdata = 32'hDEADBEEF;
        push_g(1'b0, 10'h004, 32'h0, 1'b0, 16'd0);
        rq0.push_back(32'hDEADBEEF);
        tick;
        req0 = 0;
        tick;

        // single write on requester 1
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'h12345678;
        push_g(1'b1, 10'h3FF, 32'h12345678, 1'b1, 16'd0);
        tick;
        req1 = 0;
        tick;
        tick;

        // back-to-back contention, reads on both sides
        req0 = 1; we0 = 0; addr0 = 10'h011; wdata0 = 32'h0;
        req1 = 1; we1 = 0; addr1 = 10'h022; wdata1 = 32'h0;
        mem_rdata = 32'hCAFEF00D;
        push_g(1'b0, 10'h011, 32'h0, 1'b0, 16'd1);
        push_g(1'b1, 10'h022, 32'h0, 1'b0, 16'd2);
        push_g(1'b0, 10'h011, 32'h0, 1'b0, 16'd3);
        push_g(1'b1, 10'h022, 32'h0, 1'b0, 16'd4);
        repeat (2) begin
            rq0.push_back(32'hCAFEF00D);
            rq1.push_back(32'hCAFEF00D);
        end
        repeat (4) tick;
        req0 = 0; req1 = 0;
        tick;
        tick;

        // lone write by 0, then a tie: RR favours 1, fixed favours 0
        req0 = 1; we0 = 1; addr0 = 10'h055; wdata0 = 32'hA5A5A5A5;
        push_g(1'b0, 10'h055, 32'hA5A5A5A5, 1'b1, 16'd4);
        tick;
        req0 = 0;
        tick;
        req0 = 1; we0 = 1; addr0 = 10'h100; wdata0 = 32'h1;
        req1 = 1; we1 = 0; addr1 = 10'h200; wdata1 = 32'h2;
        mem_rdata = 32'h0BADF00D;
        if (!first) begin
            push_g(1'b0, 10'h100, 32'h1, 1'b1, 16'd5);
            push_g(1'b1, 10'h200, 32'h2, 1'b0, 16'd6);
        end else begin
            push_g(1'b1, 10'h200, 32'h2, 1'b0, 16'd5);
            push_g(1'b0, 10'h100, 32'h1, 1'b1, 16'd6);
        end
        rq1.push_back(32'h0BADF00D);
        tick;
        if (!first) req0 = 0; else req1 = 0;
        tick;
        req0 = 0; req1 = 0;
        tick;
        tick;
        chk("cnt_after_tie", {16'd0, conflict_cnt}, 32'd6);

        // reset during a granted read: the response must be dropped
        req0 = 1; we0 = 0; addr0 = 10'h007; wdata0 = 32'h0;
        mem_rdata = 32'h55AA55AA;
        push_g(1'b0, 10'h007, 32'h0, 1'b0, 16'd6);
        tick;
        @(negedge CLK);
        #1;
        RSTn = 1'b0;
        req0 = 0;
        @(negedge CLK);
        chk_all_zero("midreset");
        tick;
        RSTn = 1'b1;
        repeat (3) tick;
        @(negedge CLK);
        chk("post_reset_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("post_reset_cnt", {16'd0, conflict_cnt}, 32'd0);

        // saturation of the conflict counter
        tick;
        sb_on = 1'b0;
        req0 = 1; we0 = 1; addr0 = 10'h001; wdata0 = 32'h0;
        req1 = 1; we1 = 1; addr1 = 10'h002; wdata1 = 32'h0;
        repeat (70000) tick;
        @(negedge CLK);
        chk("cnt_saturated", {16'd0, conflict_cnt}, 32'h0000FFFF);
        repeat (5) tick;
        @(negedge CLK);
        chk("cnt_no_wrap", {16'd0, conflict_cnt}, 32'h0000FFFF);
        tick;
        req0 = 0; req1 = 0;
        repeat (3) tick;

        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("rd0_queue_drained", rq0.size(), 32'd0);
        chk("rd1_queue_drained", rq1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the data-memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data-memory word width.
REQ-003 The block SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0, we0  input  1 each  CPU-core request and write-enable (requester 0).
REQ-006 The block SHALL have ports addr0 / wdata0  input  ADDR_W / DATA_W  CPU-core address and write data.
REQ-007 The block SHALL have ports req1, we1, addr1, wdata1, with the same widths, for the loader/debug requester (requester 1).
REQ-008 The block SHALL have ports gnt0, gnt1  output  1 each  registered grant, one cycle per transaction.
REQ-009 The block SHALL have ports rvalid0, rvalid1  output  1 each, and rdata0, rdata1  output  DATA_W each: read response.
REQ-010 The block SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, and mem_we, mem_re  output  1 each: single-port DMEM drive.
REQ-011 The block SHALL have port mem_rdata  input  DATA_W  DMEM read data, valid one cycle after mem_re.
REQ-012 The block SHALL have port conflict_cnt  output  16  saturating count of contended cycles.

Function
REQ-013 The FSM SHALL have the states IDLE, GNT0 and GNT1, with exactly one state active at a time.
REQ-014 From IDLE, the FSM SHALL go to GNT0 if only req0 is set, to GNT1 if only req1 is set, to the REQ-020 winner if both are set, and otherwise stay in IDLE.
REQ-015 From GNT0, the FSM SHALL go to GNT1 if req1 is set, otherwise to IDLE, and SHALL ignore req0 in that cycle. GNT1 SHALL behave symmetrically.
REQ-016 In GNTx, gntx SHALL be 1 and the block SHALL drive mem_addr=addrx, mem_wdata=wdatax, mem_we=wex and mem_re=!wex. The other grant SHALL be 0.
REQ-017 In IDLE, gnt0, gnt1, mem_we and mem_re SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-018 A requester SHALL hold req/we/addr/wdata stable from assertion until it sees gnt. The block samples them only in the grant cycle.
REQ-019 For a granted read, the block SHALL pulse rvalidx high for exactly one cycle, the cycle after gntx, with rdatax=mem_rdata. A write SHALL produce no rvalid.
REQ-020 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-027/REQ-028.
REQ-021 conflict_cnt SHALL increment by 1 on each cycle where one requester is pending without a grant while the other holds gnt, or both are requesting in IDLE. It SHALL saturate at 16'hFFFF.
REQ-022 Latency from req to gnt SHALL be 1 cycle uncontended and at most 3 cycles contended.
REQ-023 The arbiter SHALL NOT grant both requesters in the same cycle, and SHALL NOT assert mem_we and mem_re together.

Reset
REQ-024 While RSTn=0, the FSM SHALL be in IDLE and gnt0, gnt1, rvalid0, rvalid1, mem_we and mem_re SHALL be 0.
REQ-025 While RSTn=0, rdata0, rdata1, mem_addr, mem_wdata and conflict_cnt SHALL be 0, and the last-grant pointer SHALL be 1.
REQ-026 A reset asserted mid-transaction SHALL cancel any pending rvalid, and no response SHALL appear after reset release.

Configuration
REQ-027 With DMEM_ARB_RR_EN defined, an IDLE tie SHALL grant the requester not granted last. The last-grant pointer SHALL update on every grant.
REQ-028 Without DMEM_ARB_RR_EN, an IDLE tie SHALL always grant requester 0, and the pointer logic SHALL be absent.

Verification
REQ-029 Single read: req0=1, we0=0, addr0=10'h004, mem_rdata=32'hDEADBEEF -> gnt0 in cycle 1 with mem_re=1 and mem_addr=4; rvalid0=1 and rdata0=32'hDEADBEEF in cycle 2.
REQ-030 Single write: req1=1, we1=1, addr1=10'h3FF, wdata1=32'h12345678 -> gnt1 with mem_we=1, mem_addr=10'h3FF and mem_wdata=32'h12345678; no rvalid1.
REQ-031 Contention: req0 and req1 held high from reset release, RR enabled -> grants 0,1,0,1 alternating every cycle; conflict_cnt=1 after the first grant cycle, incrementing each cycle.
REQ-032 Fixed priority (macro off): both requesting in IDLE -> gnt0 first, then gnt1 the next cycle, even if req0 is reasserted.
REQ-033 Reset mid-read: gnt0 read, then RSTn=0 in the next cycle before the clock edge -> rvalid0 stays 0; all outputs 0 and FSM in IDLE.
REQ-034 Saturation: force 70000 contended cycles -> conflict_cnt=16'hFFFF and it does not wrap.
